periph_regfile: RTL and testbench



---
 rtl/periph_regfile.sv | 130 +++++++++++++
 tb/tb_periph_regfile.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/periph_regfile.sv
// Bus-attached register file with ID/CTRL/IO registers, a set-only write lock and a
// fixed-latency, fully pipelined response path.
module periph_regfile #(
    parameter int NUM_REGS   = 32,
    parameter int ADDR_W     = 24,
    parameter int RD_LATENCY = 1,
    parameter int IO_W       = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [3:0]        be_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic              gnt_o,
    output logic              rvalid_o,
    output logic [31:0]       rdata_o,
    output logic              err_o,
    output logic [IO_W-1:0]   io_out_o,
    output logic [IO_W-1:0]   io_oeb_o
);
    localparam int IDX_W = $clog2(NUM_REGS);
    localparam logic [7:0] ID_LOW = 8'(NUM_REGS - 1);

    logic            gnt_q;
    logic            lock_q;
    logic [IO_W-1:0] io_out_q;
    logic [IO_W-1:0] io_oeb_q;
    logic [31:0]     regs_q [NUM_REGS];

    logic             rv_q [RD_LATENCY];
    logic             re_q [RD_LATENCY];
    logic [31:0]      rd_q [RD_LATENCY];

    logic             accept;
    logic [IDX_W-1:0] idx;
    logic             dec_err;
    logic             lock_err;
    logic             resp_err;
    logic             wr_en;
    logic [31:0]      cur_val;
    logic [31:0]      wr_data_d;
    logic [31:0]      resp_data;

    function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
        logic [31:0] r;
        r = old_v;
        for (int n = 0; n < 4; n++) begin
            if (be[n]) r[8*n +: 8] = new_v[8*n +: 8];
        end
        return r;
    endfunction

    assign accept   = req_i & gnt_q;
    assign idx      = addr_i[IDX_W+1:2];
    assign dec_err  = (addr_i[1:0] != 2'b00) | (|addr_i[ADDR_W-1:IDX_W+2]);
    // ID and CTRL stay writable under lock so software can always probe the block.
    assign lock_err = we_i & lock_q & (idx >= IDX_W'(2));
    assign resp_err = dec_err | lock_err;
    assign wr_en    = accept & we_i & ~resp_err;

    always_comb begin
        cur_val = '0;
        if (idx == IDX_W'(0))      cur_val = {16'hCAFE, 8'h00, ID_LOW};
        else if (idx == IDX_W'(1)) cur_val = {31'b0, lock_q};
        else if (idx == IDX_W'(2)) cur_val = 32'(io_out_q);
        else if (idx == IDX_W'(3)) cur_val = 32'(io_oeb_q);
        else                       cur_val = regs_q[idx];
    end

    assign wr_data_d = be_merge(cur_val, wdata_i, be_i);
    assign resp_data = (we_i | dec_err) ? 32'h0 : cur_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q    <= 1'b0;
            lock_q   <= 1'b0;
            io_out_q <= '0;
            io_oeb_q <= '1;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            gnt_q <= 1'b1;
            if (wr_en) begin
                if (idx == IDX_W'(1)) begin
                    if (be_i[0] && wdata_i[0]) lock_q <= 1'b1;
                end else if (idx == IDX_W'(2)) begin
                    io_out_q <= wr_data_d[IO_W-1:0];
                end else if (idx == IDX_W'(3)) begin
                    io_oeb_q <= wr_data_d[IO_W-1:0];
                end else if (idx >= IDX_W'(4)) begin
                    regs_q[idx] <= wr_data_d;
                end
            end
        end
    end

    // Data/err stages only load behind a valid entry, so the outputs hold between responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < RD_LATENCY; k++) begin
                rv_q[k] <= 1'b0;
                re_q[k] <= 1'b0;
                rd_q[k] <= '0;
            end
        end else begin
            rv_q[0] <= accept;
            if (accept) begin
                re_q[0] <= resp_err;
                rd_q[0] <= resp_data;
            end
            for (int k = 1; k < RD_LATENCY; k++) begin
                rv_q[k] <= rv_q[k-1];
                if (rv_q[k-1]) begin
                    re_q[k] <= re_q[k-1];
                    rd_q[k] <= rd_q[k-1];
                end
            end
        end
    end

    assign gnt_o    = gnt_q;
    assign rvalid_o = rv_q[RD_LATENCY-1];
    assign err_o    = re_q[RD_LATENCY-1];
    assign rdata_o  = rd_q[RD_LATENCY-1];
    assign io_out_o = io_out_q;
    assign io_oeb_o = io_oeb_q;
endmodule

// File: tb/tb_periph_regfile.sv
// Table-driven bench for periph_regfile: expected responses queue up at acceptance and are
// matched (data, err, arrival cycle) when rvalid_o fires; IO pins are checked after each edge.
module tb_periph_regfile;
    localparam int NUM_REGS   = 32;
    localparam int ADDR_W     = 24;
    localparam int RD_LATENCY = 3;
    localparam int IO_W       = 32;
    localparam int W          = 65;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_i = 1'b0;
    logic              we_i = 1'b0;
    logic [3:0]        be_i = 4'h0;
    logic [ADDR_W-1:0] addr_i = '0;
    logic [31:0]       wdata_i = '0;
    logic              gnt_o;
    logic              rvalid_o;
    logic [31:0]       rdata_o;
    logic              err_o;
    logic [IO_W-1:0]   io_out_o;
    logic [IO_W-1:0]   io_oeb_o;

    periph_regfile #(
        .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .RD_LATENCY(RD_LATENCY), .IO_W(IO_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .we_i(we_i), .be_i(be_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
        .rdata_o(rdata_o), .err_o(err_o), .io_out_o(io_out_o), .io_oeb_o(io_oeb_o)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    int rv_count = 0;
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic              we;
        logic [3:0]        be;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
        logic              exp_err;
        logic [31:0]       exp_data;
        logic [31:0]       exp_out;
        logic [31:0]       exp_oeb;
    } vec_t;
    vec_t tab1[$];
    vec_t tab2[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input int t, input logic we, input logic [3:0] be,
                       input logic [ADDR_W-1:0] addr, input logic [31:0] wdata,
                       input logic e, input logic [31:0] d,
                       input logic [31:0] o, input logic [31:0] oeb);
        vec_t v;
        v.we = we; v.be = be; v.addr = addr; v.wdata = wdata;
        v.exp_err = e; v.exp_data = d; v.exp_out = o; v.exp_oeb = oeb;
        if (t == 1) tab1.push_back(v);
        else        tab2.push_back(v);
    endtask

    // Driver: called at a negedge; returns at the following negedge so calls chain back-to-back.
    task automatic issue(input vec_t v, input bit push);
        req_i = 1'b1; we_i = v.we; be_i = v.be; addr_i = v.addr; wdata_i = v.wdata;
        @(posedge clk);
        #1;
        if (push) exp_q.push_back({32'(cyc + RD_LATENCY - 1), v.exp_err, v.exp_data});
        check("io_out", io_out_o, v.exp_out);
        check("io_oeb", io_oeb_o, v.exp_oeb);
        @(negedge clk);
        req_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard: every response must match the oldest expectation, including its arrival cycle.
    always @(negedge clk) begin
        if (rvalid_o) begin
            logic [W-1:0] e;
            rv_count++;
            if (exp_q.size() == 0) begin
                check("unexpected_rvalid", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("rdata", rdata_o, e[31:0]);
                check("err", 32'(err_o), 32'(e[32]));
                check("lat", 32'(cyc), e[64:33]);
            end
        end
    end

    initial begin
        int rv_before;
        vec_t v;

        //   t we be    addr      wdata         err data          out           oeb
        add(1, 0, 4'h0, 24'h00,   32'h0,        0, 32'hCAFE001F, 32'h0,       32'hFFFFFFFF);
        add(1, 1, 4'h5, 24'h10,   32'h12345678, 0, 32'h0,        32'h0,       32'hFFFFFFFF);
        add(1, 0, 4'h0, 24'h10,   32'h0,        0, 32'h00340078, 32'h0,       32'hFFFFFFFF);
        add(1, 1, 4'hF, 24'h10,   32'h1,        0, 32'h0,        32'h0,       32'hFFFFFFFF);
        add(1, 1, 4'hF, 24'h14,   32'h2,        0, 32'h0,        32'h0,       32'hFFFFFFFF);
        add(1, 1, 4'hF, 24'h18,   32'h3,        0, 32'h0,        32'h0,       32'hFFFFFFFF);
        add(1, 0, 4'h0, 24'h10,   32'h0,        0, 32'h1,        32'h0,       32'hFFFFFFFF);
        add(1, 0, 4'h0, 24'h14,   32'h0,        0, 32'h2,        32'h0,       32'hFFFFFFFF);
        add(1, 0, 4'h0, 24'h18,   32'h0,        0, 32'h3,        32'h0,       32'hFFFFFFFF);
        add(1, 0, 4'h0, 24'h80,   32'h0,        1, 32'h0,        32'h0,       32'hFFFFFFFF);
        add(1, 0, 4'h0, 24'h11,   32'h0,        1, 32'h0,        32'h0,       32'hFFFFFFFF);
        add(1, 1, 4'hF, 24'h81,   32'hFFFFFFFF, 1, 32'h0,        32'h0,       32'hFFFFFFFF);
        add(1, 1, 4'hF, 24'h11,   32'hFFFFFFFF, 1, 32'h0,        32'h0,       32'hFFFFFFFF);
        add(1, 1, 4'hF, 24'h1008, 32'hFFFFFFFF, 1, 32'h0,        32'h0,       32'hFFFFFFFF);
        add(1, 0, 4'h0, 24'h10,   32'h0,        0, 32'h1,        32'h0,       32'hFFFFFFFF);
        add(1, 0, 4'h0, 24'h00,   32'h0,        0, 32'hCAFE001F, 32'h0,       32'hFFFFFFFF);
        add(1, 1, 4'hF, 24'h08,   32'hA5,       0, 32'h0,        32'hA5,      32'hFFFFFFFF);
        add(1, 1, 4'hF, 24'h0C,   32'h0,        0, 32'h0,        32'hA5,      32'h0);
        add(1, 0, 4'h0, 24'h08,   32'h0,        0, 32'hA5,       32'hA5,      32'h0);
        add(1, 0, 4'h0, 24'h0C,   32'h0,        0, 32'h0,        32'hA5,      32'h0);
        add(1, 1, 4'h2, 24'h08,   32'h00001200, 0, 32'h0,        32'h12A5,    32'h0);
        add(1, 0, 4'h0, 24'h08,   32'h0,        0, 32'h12A5,     32'h12A5,    32'h0);
        add(1, 1, 4'hF, 24'h08,   32'hA5,       0, 32'h0,        32'hA5,      32'h0);
        add(1, 1, 4'h0, 24'h14,   32'hFFFFFFFF, 0, 32'h0,        32'hA5,      32'h0);
        add(1, 0, 4'h0, 24'h14,   32'h0,        0, 32'h2,        32'hA5,      32'h0);
        add(1, 1, 4'hF, 24'h00,   32'hFFFFFFFF, 0, 32'h0,        32'hA5,      32'h0);
        add(1, 0, 4'h0, 24'h00,   32'h0,        0, 32'hCAFE001F, 32'hA5,      32'h0);
        add(1, 1, 4'hA, 24'h18,   32'hAABBCCDD, 0, 32'h0,        32'hA5,      32'h0);
        add(1, 0, 4'h0, 24'h18,   32'h0,        0, 32'hAA00CC03, 32'hA5,      32'h0);
        add(1, 1, 4'hF, 24'h7C,   32'h55AA55AA, 0, 32'h0,        32'hA5,      32'h0);
        add(1, 0, 4'h0, 24'h7C,   32'h0,        0, 32'h55AA55AA, 32'hA5,      32'h0);
        add(1, 1, 4'hE, 24'h04,   32'h1,        0, 32'h0,        32'hA5,      32'h0);
        add(1, 0, 4'h0, 24'h04,   32'h0,        0, 32'h0,        32'hA5,      32'h0);
        add(1, 1, 4'hF, 24'h04,   32'hFFFFFFFF, 0, 32'h0,        32'hA5,      32'h0);
        add(1, 0, 4'h0, 24'h04,   32'h0,        0, 32'h1,        32'hA5,      32'h0);
        add(1, 1, 4'hF, 24'h08,   32'hFF,       1, 32'h0,        32'hA5,      32'h0);
        add(1, 0, 4'h0, 24'h08,   32'h0,        0, 32'hA5,       32'hA5,      32'h0);
        add(1, 1, 4'hF, 24'h0C,   32'hFFFFFFFF, 1, 32'h0,        32'hA5,      32'h0);
        add(1, 1, 4'hF, 24'h04,   32'h0,        0, 32'h0,        32'hA5,      32'h0);
        add(1, 0, 4'h0, 24'h04,   32'h0,        0, 32'h1,        32'hA5,      32'h0);
        add(1, 1, 4'hF, 24'h10,   32'hDEAD,     1, 32'h0,        32'hA5,      32'h0);
        add(1, 0, 4'h0, 24'h10,   32'h0,        0, 32'h1,        32'hA5,      32'h0);
        add(1, 1, 4'hF, 24'h00,   32'h0,        0, 32'h0,        32'hA5,      32'h0);
        add(1, 0, 4'h0, 24'h7C,   32'h0,        0, 32'h55AA55AA, 32'hA5,      32'h0);
        // After the mid-flight reset: lock, registers and pins back to reset values.
        add(2, 0, 4'h0, 24'h04,   32'h0,        0, 32'h0,        32'h0,       32'hFFFFFFFF);
        add(2, 0, 4'h0, 24'h10,   32'h0,        0, 32'h0,        32'h0,       32'hFFFFFFFF);
        add(2, 0, 4'h0, 24'h7C,   32'h0,        0, 32'h0,        32'h0,       32'hFFFFFFFF);
        add(2, 0, 4'h0, 24'h08,   32'h0,        0, 32'h0,        32'h0,       32'hFFFFFFFF);
        add(2, 1, 4'hF, 24'h08,   32'h77,       0, 32'h0,        32'h77,      32'hFFFFFFFF);
        add(2, 0, 4'h0, 24'h08,   32'h0,        0, 32'h77,       32'h77,      32'hFFFFFFFF);

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_gnt", 32'(gnt_o), 32'd0);
        check("rst_rvalid", 32'(rvalid_o), 32'd0);
        check("rst_rdata", rdata_o, 32'h0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_io_out", io_out_o, 32'h0);
        check("rst_io_oeb", io_oeb_o, 32'hFFFFFFFF);
        rst_n = 1'b1;
        #1;
        check("gnt_before_edge", 32'(gnt_o), 32'd0);
        @(posedge clk);
        #1;
        check("gnt_after_edge", 32'(gnt_o), 32'd1);
        @(negedge clk);

        foreach (tab1[i]) issue(tab1[i], 1'b1);
        drain();

        // Two reads in flight, then reset: neither may respond.
        v = tab1[6];
        v.exp_out = 32'hA5; v.exp_oeb = 32'h0;
        issue(v, 1'b0);
        issue(v, 1'b0);
        rv_before = rv_count;
        rst_n = 1'b0;
        #1;
        check("midrst_io_out", io_out_o, 32'h0);
        check("midrst_io_oeb", io_oeb_o, 32'hFFFFFFFF);
        check("midrst_gnt", 32'(gnt_o), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("flushed_rvalid", 32'(rv_count - rv_before), 32'd0);

        foreach (tab2[i]) issue(tab2[i], 1'b1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
